// File: rtl/divider.sv
// divider
// 32-bit restoring divider with signed/unsigned modes.
// Magnitudes are latched in LOAD, one quotient bit is produced per ITER edge,
// and FIX applies the result signs (or the divide-by-zero convention) before
// parking in DONE. Dropping enable at any edge abandons the work and clears
// every register, so a new operation always starts from IDLE.

module divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        sign,
  input  logic        enable,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        divready,
  output logic        divzero
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Sequencing
  logic [2:0]  r_state;
  logic [5:0]  r_count;

  // Operation context captured in LOAD
  logic [31:0] r_divisorMag;
  logic [31:0] r_dividendRaw;
  logic        r_negQ;
  logic        r_negR;
  logic        r_zeroFlag;

  // Working registers for the restoring loop
  logic [32:0] r_partRem;
  logic [31:0] r_quoReg;

  // Registered results
  logic [31:0] r_quotient;
  logic [31:0] r_remainder;
  logic        r_divready;
  logic        r_divzero;

  // Operand conditioning and the per-step trial subtraction
  logic [31:0] w_dividendMag;
  logic [31:0] w_divisorMag;
  logic        w_divisorZero;
  logic [33:0] w_shiftRem;
  logic [33:0] w_trial;
  logic        w_trialNeg;
  logic [31:0] w_quoFinal;
  logic [31:0] w_remFinal;
  logic        w_clear;

  // A negative two's-complement operand is only negated in signed mode;
  // unsigned operands with bit 31 set stay full 32-bit magnitudes.
  assign w_dividendMag = (sign && dividend[31]) ? (~dividend + 32'd1) : dividend;
  assign w_divisorMag  = (sign && divisor[31])  ? (~divisor + 32'd1)  : divisor;
  assign w_divisorZero = (divisor == 32'd0);

  // The shifted remainder is widened by one bit so that the borrow out of the
  // trial subtraction lands in bit 33 for every possible divisor magnitude.
  assign w_shiftRem = {r_partRem, r_quoReg[31]};
  assign w_trial    = w_shiftRem - {2'b00, r_divisorMag};
  assign w_trialNeg = w_trial[33];

  // The partial remainder never exceeds the divisor, so its low 32 bits hold
  // the full remainder magnitude once the loop is finished.
  assign w_quoFinal = r_negQ ? (~r_quoReg + 32'd1) : r_quoReg;
  assign w_remFinal = r_negR ? (~r_partRem[31:0] + 32'd1) : r_partRem[31:0];

  // Reset and a dropped enable have the same effect: everything back to zero.
  assign w_clear = reset || !enable;

  // State and iteration counter: IDLE -> LOAD -> ITER x32 -> FIX -> DONE
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state <= S_IDLE;
      r_count <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count <= 6'd32;
          r_state <= w_divisorZero ? S_FIX : S_ITER;
        end
        S_ITER: begin
          r_count <= r_count - 6'd1;
          if (r_count == 6'd1) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= 6'd0;
        end
      endcase
    end
  end

  // Operand capture in LOAD and one restoring step per ITER edge
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_divisorMag  <= 32'd0;
      r_dividendRaw <= 32'd0;
      r_negQ        <= 1'b0;
      r_negR        <= 1'b0;
      r_zeroFlag    <= 1'b0;
      r_partRem     <= 33'd0;
      r_quoReg      <= 32'd0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_divisorMag  <= w_divisorMag;
          r_dividendRaw <= dividend;
          r_negQ        <= sign && (dividend[31] ^ divisor[31]);
          r_negR        <= sign && dividend[31];
          r_zeroFlag    <= w_divisorZero;
          r_partRem     <= 33'd0;
          r_quoReg      <= w_dividendMag;
        end
        S_ITER: begin
          if (!w_trialNeg) begin
            r_partRem <= w_trial[32:0];
            r_quoReg  <= {r_quoReg[30:0], 1'b1};
          end else begin
            r_partRem <= w_shiftRem[32:0];
            r_quoReg  <= {r_quoReg[30:0], 1'b0};
          end
        end
        default: begin
          r_partRem <= r_partRem;
          r_quoReg  <= r_quoReg;
        end
      endcase
    end
  end

  // Result registers: written once in FIX, then held through DONE
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_quotient  <= 32'd0;
      r_remainder <= 32'd0;
      r_divready  <= 1'b0;
      r_divzero   <= 1'b0;
    end else if (r_state == S_FIX) begin
      r_divready <= 1'b1;
      if (r_zeroFlag) begin
        r_quotient  <= 32'hFFFF_FFFF;
        r_remainder <= r_dividendRaw;
        r_divzero   <= 1'b1;
      end else begin
        r_quotient  <= w_quoFinal;
        r_remainder <= w_remFinal;
        r_divzero   <= 1'b0;
      end
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign divready  = r_divready;
  assign divzero   = r_divzero;

endmodule

// File: tb/tb_divider.sv
// tb_divider
// Directed and randomised checks of the divider: reset state, unsigned and
// signed results, divide by zero, signed overflow, and abort via enable/reset.
// Expected results are queued when an operation is launched and popped when
// the divider reports divready.

module tb_divider;

  logic        clk;
  logic        reset;
  logic        sign;
  logic        enable;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divready;
  logic        divzero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    string       tag;
  } expT;

  expT scoreboard[$];

  int checkCount = 0;
  int failCount  = 0;

  divider dut (
    .clk       (clk),
    .reset     (reset),
    .sign      (sign),
    .enable    (enable),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .divready  (divready),
    .divzero   (divzero)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something unexpected stalls the sequence
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input logic [31:0] q, input logic [31:0] r, input logic dz, input string tag);
    expT e;
    e.q   = q;
    e.r   = r;
    e.dz  = dz;
    e.lat = dz ? 3 : 35;
    e.tag = tag;
    scoreboard.push_back(e);
  endtask

  // Reference result built from the language's own division operators
  task automatic modelDiv(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output logic dz);
    int sa;
    int sb;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q  = 32'h8000_0000;
      r  = 32'd0;
      dz = 1'b0;
    end else if (s) begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
      dz = 1'b0;
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 1'b0;
    end
  endtask

  // Counts enabled edges until divready, scrambling the operands after LOAD
  task automatic waitResult(output int edges);
    bit got;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 2) begin
        sign     = 1'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
      end
      if (divready === 1'b1) got = 1'b1;
    end
  endtask

  // Pops the oldest expectation, compares, checks hold, then releases enable
  task automatic checkOutput(input int edges);
    expT e;
    if (scoreboard.size() == 0) begin
      checkValue("scoreboardEmpty", 32'd0, 32'd1);
      return;
    end
    e = scoreboard.pop_front();
    checkValue({e.tag, ".latency"}, 32'(edges), 32'(e.lat));
    checkValue({e.tag, ".divready"}, {31'd0, divready}, 32'd1);
    checkValue({e.tag, ".quotient"}, quotient, e.q);
    checkValue({e.tag, ".remainder"}, remainder, e.r);
    checkValue({e.tag, ".divzero"}, {31'd0, divzero}, {31'd0, e.dz});
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkValue({e.tag, ".holdQ"}, quotient, e.q);
    checkValue({e.tag, ".holdR"}, remainder, e.r);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkValue({e.tag, ".clearQ"}, quotient, 32'd0);
    checkValue({e.tag, ".clearR"}, remainder, 32'd0);
    checkValue({e.tag, ".clearReady"}, {31'd0, divready}, 32'd0);
    checkValue({e.tag, ".clearZero"}, {31'd0, divzero}, 32'd0);
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] q, input logic [31:0] r, input logic dz,
                               input string tag);
    int edges;
    pushExpected(q, r, dz, tag);
    @(negedge clk);
    sign     = s;
    dividend = a;
    divisor  = b;
    enable   = 1'b1;
    waitResult(edges);
    checkOutput(edges);
  endtask

  task automatic checkAllZero(input string tag);
    checkValue({tag, ".q"}, quotient, 32'd0);
    checkValue({tag, ".r"}, remainder, 32'd0);
    checkValue({tag, ".ready"}, {31'd0, divready}, 32'd0);
    checkValue({tag, ".zero"}, {31'd0, divzero}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [31:0] mq;
    logic [31:0] mr;
    logic        mz;
    int          edges;

    $display("[TB] divider bench starting");
    reset    = 1'b1;
    enable   = 1'b1;
    sign     = 1'b0;
    dividend = 32'd100;
    divisor  = 32'd7;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkAllZero("resetState");
    reset  = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Directed cases
    applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "u100div7");
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "sNeg7div2");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, "uMaxDiv16");
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h10, 32'h0, 32'hFFFF_FFFF, 1'b0, "sNeg1Div16");
    applyStimulus(1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, "u1234div0");
    applyStimulus(1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1, "sNegDiv0");
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, "sOverflow");
    applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, "uTopBit");
    applyStimulus(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, "s100divNeg7");

    // Randomised operands against the reference model
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      rs = 1'(i);
      if (rb == 32'd0) rb = 32'd3;
      modelDiv(rs, ra, rb, mq, mr, mz);
      applyStimulus(rs, ra, rb, mq, mr, mz, $sformatf("rand%0d", i));
    end

    // Abort by dropping enable on the 10th ITER edge, then a clean restart
    @(negedge clk);
    sign     = 1'b0;
    dividend = 32'd99999;
    divisor  = 32'd13;
    enable   = 1'b1;
    repeat (11) begin
      @(posedge clk);
      @(negedge clk);
    end
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("enableAbort");
    applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "afterEnableAbort");

    // Abort by reset on the 20th ITER edge while enable stays high
    @(negedge clk);
    sign     = 1'b1;
    dividend = 32'hFFFF_0000;
    divisor  = 32'd9;
    enable   = 1'b1;
    repeat (21) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset    = 1'b1;
    sign     = 1'b0;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("resetAbort");
    pushExpected(32'd14, 32'd2, 1'b0, "afterResetAbort");
    reset = 1'b0;
    waitResult(edges);
    checkOutput(edges);

    // Reset while parked in DONE must win over a high enable
    @(negedge clk);
    sign     = 1'b0;
    dividend = 32'd55;
    divisor  = 32'd0;
    enable   = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkValue("doneBeforeReset.ready", {31'd0, divready}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("resetInDone");
    reset  = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);

    checkValue("scoreboardDrained", 32'(scoreboard.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
